// File: rtl/multiword_adder_seq.sv
// Sequential multi-word adder: one N-bit slice adder stepped over WORDS cycles with a registered carry.
// Define ADDSEQ_SUB_EN to build two's-complement subtraction (sub input honoured at accept).
module multiword_adder_seq #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             sub,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [N*WORDS-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int W     = N * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;

    logic [W-1:0]     b_in;
    logic             cin_in;

`ifdef ADDSEQ_SUB_EN
    // Subtraction is a + ~b + 1: invert b once at capture and seed the carry.
    assign b_in   = sub ? ~b : b;
    assign cin_in = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_in       = b;
    assign cin_in     = 1'b0;
`endif

    // The single shared slice adder; the extra top bit is its carry out.
    logic [N:0] slice_sum;
    assign slice_sum = {1'b0, a_q[idx_q*N +: N]} + {1'b0, b_q[idx_q*N +: N]} + {{N{1'b0}}, carry_q};

    // NOTE: every *_d gets its hold value first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (start && !flush) begin
                    state_d  = RUN;
                    a_d      = a;
                    b_d      = b_in;
                    carry_d  = cin_in;
                    result_d = '0;
                    cout_d   = 1'b0;
                    zero_d   = 1'b0;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    carry_d  = 1'b0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    zero_d   = 1'b0;
                end else begin
                    result_d[idx_q*N +: N] = slice_sum[N-1:0];
                    carry_d                = slice_sum[N];
                    if (idx_q == LAST_IDX) begin
                        // Hold idx on the last slice so it never wraps inside an operation.
                        state_d = DONE;
                        cout_d  = slice_sum[N];
                        zero_d  = (result_d == '0);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: operand registers are reset along with control state; they are few flops, and a clean reset keeps sim free of X.
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == RUN) || (state_q == DONE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Directed bench for multiword_adder_seq (N=4, WORDS=4): vector table plus start/flush/reset corner sequences.
module tb_multiword_adder_seq;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, zero;
    logic [W-1:0] result;

    int n_pass  = 0;
    int n_total = 0;

    multiword_adder_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .sub(sub),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] exp_result;
        logic         exp_cout;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Issue one operation from IDLE and check latency, flags and the DONE->IDLE step.
    task automatic run_op(input vec_t v);
        int cyc;
        @(negedge clk);
        a = v.va; b = v.vb; sub = v.vsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({v.name, " busy_run"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({v.name, " latency"}, 32'(cyc), 32'(WORDS));
        check({v.name, " result"}, 32'(result), 32'(v.exp_result));
        check({v.name, " cout"}, 32'(cout), 32'(v.exp_cout));
        check({v.name, " zero"}, 32'(zero), 32'(v.exp_zero));
        @(negedge clk);
        check({v.name, " done_pulse"}, {30'd0, busy, done}, 32'd0);
        check({v.name, " result_hold"}, 32'(result), 32'(v.exp_result));
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;

        vecs.push_back('{"t1_00ff_p1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0});
        vecs.push_back('{"t2_ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{"zero_plus",  16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1});
        vecs.push_back('{"top_carry",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{"no_carry",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0});
        vecs.push_back('{"mid_ripple", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0});
`ifdef ADDSEQ_SUB_EN
        vecs.push_back('{"sub_equal",  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{"sub_borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{"sub_pos",    16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0});
`else
        vecs.push_back('{"sub_ignored", 16'h0003, 16'h0005, 1'b1, 16'h0008, 1'b0, 1'b0});
`endif

        // Reset state.
        #2;
        check("reset_outputs", {27'd0, busy, done, cout, zero, 1'b0}, 32'd0);
        check("reset_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // start re-pulsed at RUN idx=1 with other operands must be ignored.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (i == 1) begin
                a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_start_ignored", 32'(busy_cnt), 32'd5);
        check("done_start_ignored", 32'(done_cnt), 32'd1);
        check("result_start_ignored", 32'(result), 32'h3333);

        // flush together with start in IDLE: not accepted.
        flush = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush_start_idle", 32'(busy), 32'd0);
        check("flush_start_result", 32'(result), 32'h3333);

        // flush at RUN idx=2 discards the partial result with no done pulse.
        @(negedge clk);
        a = 16'h0777; b = 16'h0111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_outputs", {29'd0, done, cout, zero}, 32'd0);
        check("flush_result", 32'(result), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            done_cnt += int'(done);
            @(negedge clk);
        end
        check("flush_no_done", 32'(done_cnt), 32'd0);
        run_op('{"after_flush", 16'h0777, 16'h0111, 1'b0, 16'h0888, 1'b0, 1'b0});

        // Async reset at RUN idx=1 clears everything immediately.
        @(negedge clk);
        a = 16'h0007; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_partial", 32'(result), 32'h0008);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {30'd0, busy, done}, 32'd0);
        check("rst_mid_flags", {30'd0, cout, zero}, 32'd0);
        check("rst_mid_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            done_cnt += int'(done);
            @(negedge clk);
        end
        check("rst_no_done", 32'(done_cnt), 32'd0);
        run_op('{"after_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
